// File: rtl/ram8_arbiter.sv
// ram8_arbiter: shares one RAM8 (WIDTH x 2**AW) between two requesters.
// Each transaction is IDLE (sample and latch the command) followed by
// ACCESS (the RAM is driven for one cycle), so there is at most one
// transaction every two cycles. Every output comes straight from a flop.
// Optional build macro RAM8_ARB_FIXED_PRIO_EN: port 0 always wins a tie.
// When the macro is not defined, ties are broken round-robin.
module ram8_arbiter #(
    parameter int WIDTH = 16,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             we0,
    input  logic [AW-1:0]    addr0,
    input  logic [WIDTH-1:0] wdata0,
    output logic             gnt0,
    output logic             rvalid0,
    output logic [WIDTH-1:0] rdata0,
    input  logic             req1,
    input  logic             we1,
    input  logic [AW-1:0]    addr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt1,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata1,
    output logic             ram_load,
    output logic [AW-1:0]    ram_address,
    output logic [WIDTH-1:0] ram_in,
    input  logic [WIDTH-1:0] ram_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state_q, state_d;
    logic             ram_load_q, ram_load_d;
    logic [AW-1:0]    ram_address_q, ram_address_d;
    logic [WIDTH-1:0] ram_in_q, ram_in_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic             last_q, last_d;   // index of the port served last
    logic             win_q, win_d;     // port owning the current ACCESS
    logic             we_q, we_d;       // current ACCESS is a write
    logic             pick1;            // port 1 wins the IDLE sample

`ifdef RAM8_ARB_FIXED_PRIO_EN
    // Port 1 is served only when port 0 is not requesting.
    assign pick1 = req1 & ~req0;
`else
    // On a tie, the port that was not served last wins.
    assign pick1 = req1 & (~req0 | ~last_q);
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: leave IDLE on any request, and ACCESS always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req0 | req1) state_d = ACCESS;
            ACCESS:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; load, gnt and rvalid default to low.
    always_comb begin
        ram_load_d    = 1'b0;
        ram_address_d = ram_address_q;
        ram_in_d      = ram_in_q;
        gnt0_d        = 1'b0;
        gnt1_d        = 1'b0;
        rvalid0_d     = 1'b0;
        rvalid1_d     = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        last_d        = last_q;
        win_d         = win_q;
        we_d          = we_q;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    ram_address_d = pick1 ? addr1  : addr0;
                    ram_in_d      = pick1 ? wdata1 : wdata0;
                    ram_load_d    = pick1 ? we1    : we0;
                    we_d          = pick1 ? we1    : we0;
                    gnt0_d        = ~pick1;
                    gnt1_d        = pick1;
                    win_d         = pick1;
                    last_d        = pick1;
                end
            end
            ACCESS: begin
                // Load and gnt fall here; a read returns its data and a one-cycle valid.
                if (!we_q) begin
                    if (win_q) begin
                        rdata1_d  = ram_out;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = ram_out;
                        rvalid0_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output registers; reset drops ram_load at once, aborting any write in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_load_q    <= 1'b0;
            ram_address_q <= '0;
            ram_in_q      <= '0;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            rvalid0_q     <= 1'b0;
            rvalid1_q     <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            last_q        <= 1'b1;
            win_q         <= 1'b0;
            we_q          <= 1'b0;
        end else begin
            ram_load_q    <= ram_load_d;
            ram_address_q <= ram_address_d;
            ram_in_q      <= ram_in_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            rvalid0_q     <= rvalid0_d;
            rvalid1_q     <= rvalid1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            last_q        <= last_d;
            win_q         <= win_d;
            we_q          <= we_d;
        end
    end

    assign ram_load    = ram_load_q;
    assign ram_address = ram_address_q;
    assign ram_in      = ram_in_q;
    assign gnt0        = gnt0_q;
    assign gnt1        = gnt1_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;

endmodule

// File: doc/ram8_arbiter.md
Name: ram8_arbiter

Overview:
Two-port arbiter that shares one RAM8 (16-bit x 8) between two requesters, e.g. the CPU data port and a debug/DMA loader. It registers one command per transaction, drives the RAM's load/address/in lines, and returns read data with a one-cycle valid pulse. Default arbitration is round-robin. It sits between the requesters and the RAM8 instance.

Parameters:
WIDTH, 16, data width of RAM words and request data
AW, 3, address width (RAM8 depth = 2**AW = 8)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 transaction request
we0  input  1  requester 0 write enable (1 = write, 0 = read)
addr0  input  AW  requester 0 address
wdata0  input  WIDTH  requester 0 write data
gnt0  output  1  requester 0 grant pulse (command accepted)
rvalid0  output  1  requester 0 read data valid pulse
rdata0  output  WIDTH  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for requester 1
ram_load  output  1  to RAM8 load
ram_address  output  AW  to RAM8 address
ram_in  output  WIDTH  to RAM8 in
ram_out  input  WIDTH  from RAM8 out (combinational read)

Behaviour:
- Reset (async, immediate): state=IDLE; ram_load=0; ram_address=0; ram_in=0; gnt0/1=0; rvalid0/1=0; rdata0/1=0; last-served pointer=1, so port 0 wins the first tie.
- All outputs are registered. No combinational path from req*/addr*/wdata* to any output.
- States: IDLE, ACCESS.
- IDLE: at the clock edge, if any req is high, select a winner. Latch its addr into ram_address and its wdata into ram_in. Set ram_load = winner's we. Set gnt of the winner = 1. Record the winner and its we, update last=winner, then go to ACCESS. If no req is high, stay in IDLE with ram_load=0.
- Round-robin selection: if only one req is high, that port wins. If both are high, the port != last wins.
- ACCESS (exactly 1 cycle): ram_load, ram_address, ram_in and gnt hold their latched values.
  - Write: the RAM writes at the edge ending ACCESS.
  - Read: ram_out is captured into the winner's rdata at the edge ending ACCESS.
  - At that edge: ram_load->0 and gnt->0. For a read, the winner's rvalid->1 for exactly one cycle. Then go to IDLE.
- Latency:
  - Request to gnt visible: 1 cycle.
  - Read data valid: 2 cycles after the req-sampling edge.
  - Maximum throughput: one transaction per 2 cycles.
- Requester rules:
  - req, we, addr and wdata must be held stable from assertion until the cycle in which gnt is seen high.
  - After that edge the requester may drop req, or present a new command, which is sampled in the next IDLE.
  - Dropping req before gnt: the request is withdrawn only if it has not yet been sampled. Once sampled, the transaction completes regardless.
- rdataN holds its value until that port's next read completes. Writes never change rdata.
- rvalid of one port may coincide with gnt of the other port (the rvalid cycle is an IDLE cycle).
- ram_address and ram_in keep their last values in IDLE; only ram_load is forced to 0.
- Reset asserted during ACCESS: ram_load drops immediately, so a write in flight is aborted. No rvalid is issued and the FSM returns to IDLE.
- Address wrap: none. addr is AW bits wide and every value is legal.

Optional Feature:
RAM8_ARB_FIXED_PRIO_EN
- Defined: fixed priority. Port 0 always wins when both req are high, and the last pointer is ignored. Port 1 can starve, which is accepted for debug-loader use.
- Undefined: round-robin as above.

Test Plan:
1. Reset mid-write: port 0 writes addr 3 = 0xAAAA (completes). Then port 0 writes addr 3 = 0x5555 and reset is pulsed during its ACCESS cycle -> ram_load and gnt0 go low immediately, no rvalid; a following read of addr 3 returns 0xAAAA.
2. Single write then read: req0 writes addr 5 = 0x1234, then reads addr 5 -> gnt0 is one cycle after sampling; rvalid0 is high exactly one cycle, 2 cycles after the read was sampled; rdata0 = 0x1234; rdata1 and rvalid1 stay 0.
3. Simultaneous requests after reset, both held for four transactions: port 0 writes addr 0,1,2,3 = 0x0010..0x0013 and port 1 writes addr 4,5,6,7 = 0x0020..0x0023 -> grant order is 0,1,0,1,0,1,0,1; a readback of all eight addresses returns those values.
4. Back-to-back reads with port 0 holding req: addr 0 then addr 1 -> second gnt0 exactly 2 cycles after the first; the first rvalid0 coincides with the second IDLE sample cycle.
5. With RAM8_ARB_FIXED_PRIO_EN defined and both ports holding req for three transactions -> gnt0 three times, gnt1 never asserted; releasing req0 -> gnt1 on the next IDLE sample.
